// File: rtl/cmd_dispatch.sv
// rtl/cmd_dispatch.sv - host command dispatcher: FIFO pop, decode, peripheral handoff, aux pins, delay
// Optional peripheral-ack timeout enabled by defining CMD_DISPATCH_TIMEOUT_EN.
module cmd_dispatch #(
   parameter int DATA_W     = 8,
   parameter int AUX_N      = 2,
   parameter int PRESCALE_W = 4,
   parameter int TO_W       = 12
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                in_fifo_out_nempty,
   output logic                in_fifo_out_pop,
   input  logic [8+DATA_W-1:0] in_fifo_out_data,
   input  logic                out_fifo_in_full,
   output logic                out_fifo_in_shift,
   output logic [DATA_W-1:0]   out_fifo_in_data,
   output logic                per_req,
   output logic [1:0]          per_op,
   output logic [DATA_W-1:0]   per_wdata,
   input  logic                per_ack,
   input  logic [DATA_W-1:0]   per_rdata,
   output logic [AUX_N-1:0]    aux_out,
   output logic [AUX_N-1:0]    aux_oe,
   input  logic [AUX_N-1:0]    aux_in,
   output logic                busy,
   output logic                err
);

   localparam int CMD_W = 8 + DATA_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_PER_WAIT,
      S_DELAY,
      S_PUSH
   } state_e;

   state_e              state_q, state_d;
   logic [CMD_W-1:0]    cmd_q, cmd_d;
   logic                per_req_q, per_req_d;
   logic [1:0]          per_op_q, per_op_d;
   logic [DATA_W-1:0]   per_wdata_q, per_wdata_d;
   logic [AUX_N-1:0]    aux_out_q, aux_out_d;
   logic [AUX_N-1:0]    aux_oe_q, aux_oe_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [DATA_W-1:0]   tick_q, tick_d;
   logic [PRESCALE_W-1:0] pre_q, pre_d;
   logic                err_q, err_d;
`ifdef CMD_DISPATCH_TIMEOUT_EN
   logic [TO_W-1:0]     to_q, to_d;
`endif

   logic [7:0]          opcode;
   logic [DATA_W-1:0]   payload;
   logic                pop_c, shift_c;
   logic                aux_hit;
   logic                aux_rd_bit;

   assign opcode  = cmd_q[CMD_W-1:DATA_W];
   assign payload = cmd_q[DATA_W-1:0];

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      per_req_d   = per_req_q;
      per_op_d    = per_op_q;
      per_wdata_d = per_wdata_q;
      aux_out_d   = aux_out_q;
      aux_oe_d    = aux_oe_q;
      data_d      = data_q;
      tick_d      = tick_q;
      pre_d       = pre_q;
      err_d       = err_q;
`ifdef CMD_DISPATCH_TIMEOUT_EN
      to_d        = to_q;
`endif
      pop_c       = 1'b0;
      shift_c     = 1'b0;
      aux_hit     = 1'b0;
      aux_rd_bit  = 1'b0;

      // Channel decode by comparison keeps the payload width independent of AUX_N.
      for (int i = 0; i < AUX_N; i++) begin
         if (payload == DATA_W'(i)) begin
            aux_hit    = 1'b1;
            aux_rd_bit = aux_in[i];
         end
      end

      case (state_q)
         S_IDLE: begin
            if (in_fifo_out_nempty) begin
               cmd_d   = in_fifo_out_data;
               pop_c   = 1'b1;
               state_d = S_DECODE;
            end
         end

         S_DECODE: begin
            state_d = S_IDLE;
            case (opcode)
               8'h00, 8'h01, 8'h02: begin
                  per_req_d   = 1'b1;
                  per_op_d    = opcode[1:0];
                  per_wdata_d = payload;
`ifdef CMD_DISPATCH_TIMEOUT_EN
                  to_d        = '0;
`endif
                  state_d     = S_PER_WAIT;
               end
               8'h10: begin
                  tick_d = '0;
                  pre_d  = '0;
                  if (payload != '0) state_d = S_DELAY;
               end
               8'h20, 8'h21, 8'h22, 8'h23: begin
                  if (!aux_hit) begin
                     err_d = 1'b1;
                  end else if (opcode == 8'h23) begin
                     data_d    = '0;
                     data_d[0] = aux_rd_bit;
                     state_d   = S_PUSH;
                  end else begin
                     for (int i = 0; i < AUX_N; i++) begin
                        if (payload == DATA_W'(i)) begin
                           aux_oe_d[i] = (opcode != 8'h22);
                           if (opcode != 8'h22) aux_out_d[i] = opcode[0];
                        end
                     end
                  end
               end
               default: err_d = 1'b1;
            endcase
         end

         S_PER_WAIT: begin
            if (per_ack) begin
               per_req_d = 1'b0;
               if (per_op_q == 2'b00) begin
                  data_d  = per_rdata;
                  state_d = S_PUSH;
               end else begin
                  state_d = S_IDLE;
               end
            end
`ifdef CMD_DISPATCH_TIMEOUT_EN
            else if (to_q == '1) begin
               per_req_d = 1'b0;
               err_d     = 1'b1;
               if (per_op_q == 2'b00) begin
                  data_d  = '1;
                  state_d = S_PUSH;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               to_d = to_q + TO_W'(1);
            end
`endif
         end

         S_DELAY: begin
            if (pre_q == '1) begin
               pre_d = '0;
               if (tick_q + DATA_W'(1) == payload) begin
                  tick_d  = '0;
                  state_d = S_IDLE;
               end else begin
                  tick_d = tick_q + DATA_W'(1);
               end
            end else begin
               pre_d = pre_q + PRESCALE_W'(1);
            end
         end

         S_PUSH: begin
            if (!out_fifo_in_full) begin
               shift_c = 1'b1;
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cmd_q       <= '0;
         per_req_q   <= 1'b0;
         per_op_q    <= '0;
         per_wdata_q <= '0;
         aux_out_q   <= '0;
         aux_oe_q    <= '0;
         data_q      <= '0;
         tick_q      <= '0;
         pre_q       <= '0;
         err_q       <= 1'b0;
`ifdef CMD_DISPATCH_TIMEOUT_EN
         to_q        <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         per_req_q   <= per_req_d;
         per_op_q    <= per_op_d;
         per_wdata_q <= per_wdata_d;
         aux_out_q   <= aux_out_d;
         aux_oe_q    <= aux_oe_d;
         data_q      <= data_d;
         tick_q      <= tick_d;
         pre_q       <= pre_d;
         err_q       <= err_d;
`ifdef CMD_DISPATCH_TIMEOUT_EN
         to_q        <= to_d;
`endif
      end
   end

   // Strobes are suppressed during reset so no FIFO word is consumed or produced.
   assign in_fifo_out_pop   = pop_c & ~reset;
   assign out_fifo_in_shift = shift_c & ~reset;
   assign out_fifo_in_data  = data_q;
   assign per_req           = per_req_q;
   assign per_op            = per_op_q;
   assign per_wdata         = per_wdata_q;
   assign aux_out           = aux_out_q;
   assign aux_oe            = aux_oe_q;
   assign busy              = (state_q != S_IDLE);
   assign err               = err_q;

endmodule

// File: tb/tb_cmd_dispatch.sv
// tb/tb_cmd_dispatch.sv - directed self-checking bench for cmd_dispatch
module tb_cmd_dispatch;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        nempty = 1'b0;
   logic        pop;
   logic [15:0] fdata = '0;
   logic        full = 1'b0;
   logic        shift;
   logic [7:0]  odata;
   logic        per_req;
   logic [1:0]  per_op;
   logic [7:0]  per_wdata;
   logic        per_ack = 1'b0;
   logic [7:0]  per_rdata = '0;
   logic [1:0]  aux_out;
   logic [1:0]  aux_oe;
   logic [1:0]  aux_in = '0;
   logic        busy;
   logic        err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int shift_cnt = 0;

   cmd_dispatch dut (
      .clock              (clock),
      .reset              (reset),
      .in_fifo_out_nempty (nempty),
      .in_fifo_out_pop    (pop),
      .in_fifo_out_data   (fdata),
      .out_fifo_in_full   (full),
      .out_fifo_in_shift  (shift),
      .out_fifo_in_data   (odata),
      .per_req            (per_req),
      .per_op             (per_op),
      .per_wdata          (per_wdata),
      .per_ack            (per_ack),
      .per_rdata          (per_rdata),
      .aux_out            (aux_out),
      .aux_oe             (aux_oe),
      .aux_in             (aux_in),
      .busy               (busy),
      .err                (err)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (shift) shift_cnt <= shift_cnt + 1;
   end

   // Present one word and return at the negedge of the cycle after its pop.
   task automatic send(input logic [15:0] w, output int pc);
      pc = -1;
      nempty = 1'b1;
      fdata = w;
      #1;
      for (int n = 0; n < 300 && !pop; n++) begin
         @(negedge clock);
         #1;
      end
      checks++;
      if (!pop) begin
         errors++;
         $display("FAIL send_pop word=%h: pop=%b expected 1", w, pop);
         nempty = 1'b0;
      end else begin
         pc = cyc;
         @(negedge clock);
         nempty = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      #1;
      checks++;
      if ({pop, shift, per_req, busy, err} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: pop,shift,req,busy,err=%b expected 00000", {pop, shift, per_req, busy, err});
      end
      checks++;
      if ({aux_oe, aux_out} !== 4'b0) begin
         errors++;
         $display("FAIL reset_aux: oe,out=%b expected 0000", {aux_oe, aux_out});
      end
      checks++;
      if ({per_op, per_wdata, odata} !== 18'b0) begin
         errors++;
         $display("FAIL reset_data: op,wdata,odata=%h expected 0", {per_op, per_wdata, odata});
      end
   endtask

   task automatic test_aux();
      int pc;
      send(16'h2101, pc);
      @(negedge clock);
      checks++;
      if (aux_oe !== 2'b10 || aux_out !== 2'b10) begin
         errors++;
         $display("FAIL aux_high: oe=%b out=%b expected oe=10 out=10", aux_oe, aux_out);
      end
      send(16'h2201, pc);
      @(negedge clock);
      checks++;
      if (aux_oe !== 2'b00) begin
         errors++;
         $display("FAIL aux_hiz: oe=%b expected 00", aux_oe);
      end
   endtask

   task automatic test_per();
      int pc;
      int s0;
      s0 = shift_cnt;
      send(16'h00A5, pc);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clock);
         checks++;
         if (per_req !== 1'b1 || per_op !== 2'b00 || per_wdata !== 8'hA5) begin
            errors++;
            $display("FAIL per_req_cycle%0d: req=%b op=%b wdata=%h expected 1 00 a5", k, per_req, per_op, per_wdata);
         end
         if (k == 4) begin
            per_ack = 1'b1;
            per_rdata = 8'h3C;
         end
      end
      @(negedge clock);
      per_ack = 1'b0;
      per_rdata = 8'h00;
      #1;
      checks++;
      if (per_req !== 1'b0) begin
         errors++;
         $display("FAIL per_req_drop: req=%b expected 0", per_req);
      end
      checks++;
      if (shift !== 1'b1 || odata !== 8'h3C) begin
         errors++;
         $display("FAIL per_push: shift=%b data=%h expected 1 3c", shift, odata);
      end
      @(negedge clock);
      checks++;
      if (shift_cnt - s0 !== 1 || shift !== 1'b0) begin
         errors++;
         $display("FAIL per_shift_count: count=%0d shift=%b expected 1 0", shift_cnt - s0, shift);
      end
   endtask

   task automatic test_delay();
      int p0;
      int p1;
      int p2;
      send(16'h1003, p0);
      send(16'h1000, p1);
      send(16'h2100, p2);
      checks++;
      if (p1 - p0 !== 50) begin
         errors++;
         $display("FAIL delay_3ticks: pop gap=%0d expected 50", p1 - p0);
      end
      checks++;
      if (p2 - p1 !== 2) begin
         errors++;
         $display("FAIL delay_zero: pop gap=%0d expected 2", p2 - p1);
      end
      @(negedge clock);
   endtask

   task automatic test_full();
      int pc;
      int s0;
      logic seen;
      s0 = shift_cnt;
      seen = 1'b0;
      full = 1'b1;
      aux_in = 2'b01;
      send(16'h2300, pc);
      repeat (5) begin
         @(negedge clock);
         if (shift) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL full_hold: shift_seen=%b busy=%b expected 0 1", seen, busy);
      end
      full = 1'b0;
      #1;
      checks++;
      if (shift !== 1'b1 || odata !== 8'h01) begin
         errors++;
         $display("FAIL full_release: shift=%b data=%h expected 1 01", shift, odata);
      end
      @(negedge clock);
      checks++;
      if (shift_cnt - s0 !== 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL full_count: count=%0d busy=%b expected 1 0", shift_cnt - s0, busy);
      end
      aux_in = 2'b00;
   endtask

   task automatic test_err();
      int pc;
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL err_before: err=%b expected 0", err);
      end
      send(16'h7F00, pc);
      @(negedge clock);
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL err_bad_opcode: err=%b expected 1", err);
      end
      send(16'h2005, pc);
      @(negedge clock);
      checks++;
      if (aux_oe !== 2'b01 || aux_out !== 2'b11 || busy !== 1'b0 || pc < 0) begin
         errors++;
         $display("FAIL err_bad_channel: oe=%b out=%b busy=%b pop_cyc=%0d expected 01 11 0 >=0", aux_oe, aux_out, busy, pc);
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL err_reset: err=%b expected 0", err);
      end
   endtask

   task automatic test_reset_mid();
      int pc;
      send(16'h2101, pc);
      send(16'h0155, pc);
      @(negedge clock);
      checks++;
      if (per_req !== 1'b1 || per_op !== 2'b01 || aux_oe !== 2'b10) begin
         errors++;
         $display("FAIL mid_setup: req=%b op=%b oe=%b expected 1 01 10", per_req, per_op, aux_oe);
      end
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (per_req !== 1'b0 || aux_oe !== 2'b00 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: req=%b oe=%b busy=%b expected 0 00 0", per_req, aux_oe, busy);
      end
      reset = 1'b0;
      @(negedge clock);
   endtask

`ifdef CMD_DISPATCH_TIMEOUT_EN
   task automatic test_timeout();
      int pc;
      int n;
      send(16'h0000, pc);
      n = 0;
      while (!shift && n < 5000) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (shift !== 1'b1 || odata !== 8'hFF || err !== 1'b1) begin
         errors++;
         $display("FAIL timeout_push: shift=%b data=%h err=%b expected 1 ff 1", shift, odata, err);
      end
      @(negedge clock);
   endtask
`endif

   initial begin
      test_reset();
      test_aux();
      test_per();
      test_delay();
      test_full();
      test_err();
      test_reset_mid();
`ifdef CMD_DISPATCH_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
